// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Summary  : Round-robin, burst-bounded arbiter sharing one FIFO write port.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int IDX_SIZE  = 2,
    parameter int MAX_BURST = 4,
    parameter int CNT_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_i,
    input  logic [NREQ*WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]       ack_o,
    output logic [NREQ-1:0]       gnt_o,
    output logic                  busy_o,
    input  logic                  fifo_full_i,
    output logic                  fifo_wr_en_o,
    output logic [WIDTH-1:0]      fifo_din_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    localparam logic [CNT_SIZE-1:0] c_LAST_BEAT = CNT_SIZE'(MAX_BURST - 1);
    localparam logic [NREQ-1:0]     c_ONE       = NREQ'(1);

    state_t                state_q, state_d;
    logic [IDX_SIZE-1:0]   g_q, g_d;
    logic [IDX_SIZE-1:0]   last_q, last_d;
    logic [CNT_SIZE-1:0]   burst_cnt_q, burst_cnt_d;
    logic [NREQ-1:0]       gnt_q, gnt_d;

    logic [WIDTH-1:0]      w_lane [NREQ];
    logic                  w_wr;
    logic                  w_hit;
    logic [IDX_SIZE-1:0]   w_hit_idx;
    logic                  w_hi_found;
    logic [IDX_SIZE-1:0]   w_hi_idx;
    logic [IDX_SIZE-1:0]   w_lo_idx;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
        assign w_lane[gi] = req_data_i[gi*WIDTH +: WIDTH];
    end

    // Rotating priority: lowest requester above last wins, else wrap to lowest overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                w_lo_idx = IDX_SIZE'(i);
                if (IDX_SIZE'(i) > last_q) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IDX_SIZE'(i);
                end
            end
        end
        w_hit     = |req_i;
        w_hit_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_wr         = (state_q == S_BUSY) && req_i[g_q] && !fifo_full_i;
    assign fifo_wr_en_o = w_wr;
    assign ack_o        = w_wr ? (c_ONE << g_q) : '0;
    assign fifo_din_o   = (state_q == S_BUSY) ? w_lane[g_q] : '0;
    assign gnt_o        = gnt_q;
    assign busy_o       = |gnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            last_q      <= IDX_SIZE'(NREQ - 1);
            burst_cnt_q <= '0;
            gnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            gnt_q       <= gnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        gnt_d       = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (w_hit) begin
                    state_d     = S_BUSY;
                    g_d         = w_hit_idx;
                    last_d      = w_hit_idx;
                    burst_cnt_d = '0;
                    gnt_d       = c_ONE << w_hit_idx;
                end
            end
            S_BUSY: begin
                // last_q equals g_q here, so w_hit_idx is already the release search.
                if ((w_wr && (burst_cnt_q == c_LAST_BEAT)) || !req_i[g_q]) begin
                    if (w_hit) begin
                        g_d         = w_hit_idx;
                        last_d      = w_hit_idx;
                        burst_cnt_d = '0;
                        gnt_d       = c_ONE << w_hit_idx;
                    end else begin
                        state_d     = S_IDLE;
                        burst_cnt_d = '0;
                        gnt_d       = '0;
                    end
                end else if (w_wr) begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
